// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the sticky-status interrupt controller.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    HOLD   = 2'd2
  } irq_state_e;

  // Wide enough for the largest holdoff (15).
  localparam int HOLD_W = 4;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index-first priority encoder.
module irq_prio_enc #(
  parameter int N    = 8,
  parameter int ID_W = 3
) (
  input  logic [N-1:0]    vec,
  output logic            vld,
  output logic [ID_W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last to write idx.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        vld = 1'b1;
        idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_rc_bit.sv
// Single-bit sticky read-clear status register: trig sets, re/clr clear,
// and a set in the same cycle beats any clear.
module irq_rc_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic trig,
  input  logic re,
  input  logic clr,
  output logic q
);

  // Set has priority over both clear sources so no event is ever lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          q <= 1'b0;
    else if (trig)       q <= 1'b1;
    else if (re || clr)  q <= 1'b0;
  end

endmodule

// File: rtl/irq_status_ctrl.sv
// Interrupt controller on sticky read-clear status bits: captures source
// events into pending bits, masks them, and services the lowest-index
// eligible source through a single registered irq line with holdoff.
// Optional: define IRQ_EDGE_TRIG_EN to set pending on rising edges of
// src_trig only (adds one cycle of latency).
module irq_status_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC   = 8,
  parameter int ID_W    = 3,
  parameter int HOLDOFF = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] src_trig,
  input  logic             mask_wr,
  input  logic [N_SRC-1:0] mask_din,
  output logic [N_SRC-1:0] mask_q,
  input  logic             stat_re,
  output logic [N_SRC-1:0] stat_q,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id,
  input  logic             irq_ack,
  output logic             busy
);

  irq_state_e        state, state_n;
  logic [HOLD_W-1:0] cnt, cnt_n;
  logic              irq_n;
  logic [ID_W-1:0]   irq_id_n;

  logic [N_SRC-1:0]  set_vec;
  logic [N_SRC-1:0]  ack_vec;
  logic [N_SRC-1:0]  pending;
  logic [N_SRC-1:0]  elig;
  logic              win_vld;
  logic [ID_W-1:0]   win_idx;

`ifdef IRQ_EDGE_TRIG_EN
  logic [N_SRC-1:0]  trig_d1, trig_d2;

  // Two-stage sample of the raw triggers; a 0->1 between them is an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_d1 <= '0;
      trig_d2 <= '0;
    end else begin
      trig_d1 <= src_trig;
      trig_d2 <= trig_d1;
    end
  end

  assign set_vec = trig_d1 & ~trig_d2;
`else
  assign set_vec = src_trig;
`endif

  // Mask register; resets to all sources masked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       mask_q <= '1;
    else if (mask_wr) mask_q <= mask_din;
  end

  // One sticky status bit per source; ack only clears the in-service one.
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign ack_vec[i] = irq_ack && (state == ASSERT) && (irq_id == ID_W'(i));

    irq_rc_bit u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .trig  (set_vec[i]),
      .re    (ack_vec[i]),
      .clr   (stat_re),
      .q     (pending[i])
    );
  end

  assign stat_q = pending;
  assign elig   = pending & ~mask_q;

  irq_prio_enc #(.N(N_SRC), .ID_W(ID_W)) u_enc (
    .vec (elig),
    .vld (win_vld),
    .idx (win_idx)
  );

  // FSM and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      irq    <= 1'b0;
      irq_id <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      irq    <= irq_n;
      irq_id <= irq_id_n;
    end
  end

  // Next state: once asserted, irq is committed until ack regardless of
  // later mask or status-clear activity; new winners wait for IDLE.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    irq_n    = irq;
    irq_id_n = irq_id;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_n  = ASSERT;
          irq_n    = 1'b1;
          irq_id_n = win_idx;
        end
      end
      ASSERT: begin
        if (irq_ack) begin
          irq_n = 1'b0;
          if (HOLDOFF == 0) begin
            state_n = IDLE;
          end else begin
            state_n = HOLD;
            cnt_n   = HOLD_W'(HOLDOFF);
          end
        end
      end
      HOLD: begin
        irq_n = 1'b0;
        if (cnt <= HOLD_W'(1)) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - HOLD_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        irq_n   = 1'b0;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_irq_status_ctrl.sv
// Directed self-checking bench for irq_status_ctrl (N_SRC=8, HOLDOFF=2).
module tb_irq_status_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] src_trig;
  logic       mask_wr;
  logic [7:0] mask_din;
  logic [7:0] mask_q;
  logic       stat_re;
  logic [7:0] stat_q;
  logic       irq;
  logic [2:0] irq_id;
  logic       irq_ack;
  logic       busy;

  int passed = 0;
  int total  = 0;

  irq_status_ctrl #(.N_SRC(8), .ID_W(3), .HOLDOFF(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .src_trig (src_trig),
    .mask_wr  (mask_wr),
    .mask_din (mask_din),
    .mask_q   (mask_q),
    .stat_re  (stat_re),
    .stat_q   (stat_q),
    .irq      (irq),
    .irq_id   (irq_id),
    .irq_ack  (irq_ack),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Single-cycle trigger; returns with stat_q showing the event.
  task automatic pulse(input logic [7:0] v);
    src_trig = v;
    tick();
    src_trig = '0;
`ifdef IRQ_EDGE_TRIG_EN
    tick();
`endif
  endtask

  task automatic ack_once();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; src_trig = '0; mask_wr = 1'b0; mask_din = '0;
    stat_re = 1'b0; irq_ack = 1'b0;
    #12;
    chk("rst_stat", stat_q, 8'h00);
    chk("rst_mask", mask_q, 8'hFF);
    chk("rst_irq", irq, 1'b0);
    chk("rst_id", irq_id, 3'd0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Unmask everything.
    mask_wr = 1'b1; mask_din = 8'h00; tick(); mask_wr = 1'b0;
    chk("mask_load", mask_q, 8'h00);

    // Single event on source 2.
    pulse(8'h04);
    chk("single_stat", stat_q, 8'h04);
    chk("single_irq_c1", irq, 1'b0);
    tick();
    chk("single_irq", irq, 1'b1);
    chk("single_id", irq_id, 3'd2);
    ack_once();
    chk("single_ack_stat", stat_q, 8'h00);
    chk("single_ack_irq", irq, 1'b0);
    chk("single_hold1", busy, 1'b1);
    tick();
    chk("single_hold2", busy, 1'b1);
    tick();
    chk("single_idle", busy, 1'b0);

    // Priority: 4 before 7, no pre-emption.
    pulse(8'h90);
    chk("prio_stat", stat_q, 8'h90);
    tick();
    chk("prio_id4", irq_id, 3'd4);
    chk("prio_irq4", irq, 1'b1);
    ack_once();
    chk("prio_stat_after", stat_q, 8'h80);
    tick(); tick(); tick();
    chk("prio_irq7", irq, 1'b1);
    chk("prio_id7", irq_id, 3'd7);
    ack_once();
    chk("prio_stat_clr", stat_q, 8'h00);
    tick(); tick();

    // Masking: pending visible but no irq until unmasked.
    mask_wr = 1'b1; mask_din = 8'hFE; tick(); mask_wr = 1'b0;
    pulse(8'h02);
    chk("mask_stat", stat_q, 8'h02);
    tick(); tick();
    chk("mask_noirq", irq, 1'b0);
    mask_wr = 1'b1; mask_din = 8'h00; tick(); mask_wr = 1'b0;
    chk("mask_wr_c1", irq, 1'b0);
    tick();
    chk("unmask_irq", irq, 1'b1);
    chk("unmask_id", irq_id, 3'd1);
    ack_once();
    tick(); tick();

`ifndef IRQ_EDGE_TRIG_EN
    // Collision: retrigger in the ack cycle keeps pending set.
    pulse(8'h08);
    tick();
    chk("coll_id", irq_id, 3'd3);
    src_trig = 8'h08; irq_ack = 1'b1; tick();
    src_trig = '0; irq_ack = 1'b0;
    chk("coll_stat", stat_q, 8'h08);
    chk("coll_irq_low", irq, 1'b0);
    tick(); tick(); tick();
    chk("coll_reirq", irq, 1'b1);
    chk("coll_reid", irq_id, 3'd3);
`else
    // Held trigger through an ack yields exactly one irq, first at cycle 3.
    begin
      int n = 0;
      int first = 0;
      logic prev = 1'b0;
      src_trig = 8'h01;
      for (int i = 1; i <= 10; i++) begin
        tick();
        if (irq && !prev) begin
          n++;
          if (first == 0) first = i;
        end
        prev    = irq;
        irq_ack = irq;
      end
      src_trig = '0; irq_ack = 1'b0;
      chk("edge_first", first, 3);
      chk("edge_count", n, 1);
      tick(); tick(); tick();
      pulse(8'h08);
      tick();
      chk("coll_id", irq_id, 3'd3);
    end
`endif

    // Status read during ASSERT clears pending but irq stays committed.
    stat_re = 1'b1; tick(); stat_re = 1'b0;
    chk("re_stat", stat_q, 8'h00);
    chk("re_irq", irq, 1'b1);
    chk("re_id", irq_id, 3'd3);
    tick();
    chk("re_irq_hold", irq, 1'b1);
    ack_once();
    chk("re_ack_irq", irq, 1'b0);
    tick(); tick();

    // Async reset mid-ASSERT.
    pulse(8'h20);
    tick();
    chk("pre_rst_irq", irq, 1'b1);
    chk("pre_rst_id", irq_id, 3'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_irq", irq, 1'b0);
    chk("arst_id", irq_id, 3'd0);
    chk("arst_stat", stat_q, 8'h00);
    chk("arst_mask", mask_q, 8'hFF);
    chk("arst_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
